// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: owns the PC, runs the instruction-memory handshake and
// hands fetched PCs to decode, applying stall and branch/jump/jr redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_sl2,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic [31:0] redirect_pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  always_comb begin
    redirect = jr | jump | branch_taken;
    if (jr) begin
      redirect_target = jr_target;
    end else if (jump) begin
      redirect_target = {redirect_pc4[31:28], jump_index, 2'b00};
    end else begin
      redirect_target = redirect_pc4 + branch_offset_sl2;
    end
    pc_plus4 = pc_q + 32'd4;
  end

  // Handshake: imem_req is held high with imem_addr stable until a single-cycle
  // imem_ack; the ack completes that request. Decode takes fetch_pc whenever
  // fetch_valid is high and stall is low.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;
    case (state_q)
      BOOT: begin
        fetch_valid_d = 1'b0;
        state_d       = REQ;
      end
      REQ: begin
        fetch_valid_d = 1'b0;
        if (imem_ack) begin
          if (redirect || pend_q) begin
            // A redirect arriving with the ack beats one latched earlier.
            pc_d   = redirect ? redirect_target : pend_pc_q;
            pend_d = 1'b0;
          end else begin
            fetch_valid_d = 1'b1;
            fetch_pc_d    = pc_q;
            if (stall) begin
              state_d = STALL;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end else if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_target;
        end
      end
      STALL: begin
        if (redirect) begin
          fetch_valid_d = 1'b0;
          pc_d          = redirect_target;
          state_d       = REQ;
        end else if (!stall) begin
          fetch_valid_d = 1'b0;
          pc_d          = pc_plus4;
          state_d       = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= 32'h0;
      fetch_valid_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_pc_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: directed tasks plus a transfer scoreboard that
// pops an expected PC on every cycle decode accepts an instruction.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset_sl2 = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] redirect_pc4 = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_offset_sl2(branch_offset_sl2),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .redirect_pc4(redirect_pc4), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .pc(pc), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: a transfer to decode is fetch_valid && !stall
  always @(negedge clk) begin
    if (!rst && fetch_valid && !stall) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: transfer of fetch_pc=%h, none expected", fetch_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (fetch_pc !== exp_pc) begin
          n_errors++;
          $display("FAIL sb_fetch_pc: got %h want %h", fetch_pc, exp_pc);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] t);
    jr = 1'b1; jr_target = t; imem_ack = 1'b1;
    tick();
    jr = 1'b0; imem_ack = 1'b0;
    n_checks++;
    if (imem_addr !== t || fetch_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL goto: addr %h valid %b want %h 0", imem_addr, fetch_valid, t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (pc !== 32'h0 || fetch_pc !== 32'h0 || fetch_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: pc %h fpc %h fv %b req %b want 0 0 0 0", pc, fetch_pc, fetch_valid, imem_req);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    n_checks++;
    if (imem_req !== 1'b0) begin n_errors++; $display("FAIL boot_req: got %b want 0", imem_req); end
    imem_ack = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL boot_exit: req %b addr %h fv %b want 1 0 0", imem_req, imem_addr, fetch_valid);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'(i * 4));
      tick();
      n_checks++;
      if (fetch_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'((i + 1) * 4)) begin
        n_errors++;
        $display("FAIL seq_%0d: fv %b req %b addr %h want 1 1 %h", i, fetch_valid, imem_req, imem_addr, 32'((i + 1) * 4));
      end
    end
    imem_ack = 1'b0;
    tick();
    n_checks++;
    if (fetch_valid !== 1'b0) begin n_errors++; $display("FAIL seq_noack: fv %b want 0", fetch_valid); end
  endtask

  task automatic test_branch_squash();
    goto_pc(32'h200);
    branch_taken = 1'b1; redirect_pc4 = 32'h100; branch_offset_sl2 = 32'hFFFF_FFF0;
    tick();
    branch_taken = 1'b0;
    n_checks++;
    if (imem_addr !== 32'h200 || fetch_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL br_hold: addr %h fv %b want 200 0", imem_addr, fetch_valid);
    end
    tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (imem_addr !== 32'hF0 || fetch_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL br_squash: addr %h fv %b want f0 0", imem_addr, fetch_valid);
    end
    exp_q.push_back(32'hF0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic test_priority();
    jump = 1'b1; branch_taken = 1'b1; redirect_pc4 = 32'h4000_0010;
    jump_index = 26'h000_0040; branch_offset_sl2 = 32'h1000; imem_ack = 1'b1;
    tick();
    jump = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    n_checks++;
    if (pc !== 32'h4000_0100 || fetch_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL jump_over_branch: pc %h fv %b want 40000100 0", pc, fetch_valid);
    end
    jr = 1'b1; jr_target = 32'h0000_3000; jump = 1'b1; imem_ack = 1'b1;
    tick();
    jr = 1'b0; jump = 1'b0; imem_ack = 1'b0;
    n_checks++;
    if (pc !== 32'h0000_3000) begin n_errors++; $display("FAIL jr_over_jump: pc %h want 3000", pc); end
  endtask

  task automatic test_pending();
    jr = 1'b1; jr_target = 32'h700;
    tick();
    jr = 1'b0;
    n_checks++;
    if (imem_addr !== 32'h3000) begin n_errors++; $display("FAIL pend_hold: addr %h want 3000", imem_addr); end
    branch_taken = 1'b1; redirect_pc4 = 32'h800; branch_offset_sl2 = 32'h10; imem_ack = 1'b1;
    tick();
    branch_taken = 1'b0; imem_ack = 1'b0;
    n_checks++;
    if (pc !== 32'h810 || fetch_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL pend_override: pc %h fv %b want 810 0", pc, fetch_valid);
    end
    jr = 1'b1; jr_target = 32'h900;
    tick();
    jr = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (pc !== 32'h900 || fetch_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL pend_apply: pc %h fv %b want 900 0", pc, fetch_valid);
    end
    exp_q.push_back(32'h900);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (pc !== 32'h904) begin n_errors++; $display("FAIL pend_cleared: pc %h want 904", pc); end
  endtask

  task automatic test_stall();
    goto_pc(32'h20);
    exp_q.push_back(32'h20);
    imem_ack = 1'b1; stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_req !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 32'h20) begin
        n_errors++;
        $display("FAIL stall_hold_%0d: req %b fv %b fpc %h want 0 1 20", i, imem_req, fetch_valid, fetch_pc);
      end
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || fetch_valid !== 1'b0 || imem_addr !== 32'h24) begin
      n_errors++;
      $display("FAIL stall_release: req %b fv %b addr %h want 1 0 24", imem_req, fetch_valid, imem_addr);
    end
  endtask

  task automatic test_jr_in_stall();
    goto_pc(32'h60);
    imem_ack = 1'b1; stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    jr = 1'b1; jr_target = 32'h8000_0000;
    tick();
    jr = 1'b0;
    n_checks++;
    if (fetch_valid !== 1'b0 || imem_addr !== 32'h8000_0000 || imem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL jr_stall: fv %b addr %h req %b want 0 80000000 1", fetch_valid, imem_addr, imem_req);
    end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (pc !== 32'h0) begin n_errors++; $display("FAIL pc_wrap: pc %h want 0", pc); end
  endtask

  task automatic test_back_to_back();
    int n;
    goto_pc(32'h1000);
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        tick();
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_wait: fv %b want 0", fetch_valid); end
      end
      exp_q.push_back(32'h1000 + 32'(4 * k));
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_checks++;
      if (imem_addr !== 32'h1000 + 32'(4 * (k + 1))) begin
        n_errors++;
        $display("FAIL b2b_addr_%0d: got %h want %h", k, imem_addr, 32'h1000 + 32'(4 * (k + 1)));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    goto_pc(32'h50);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h50) begin
      n_errors++;
      $display("FAIL rm_pre: req %b addr %h want 1 50", imem_req, imem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_ack = 1'b1;
    n_checks++;
    if (pc !== 32'h0 || fetch_valid !== 1'b0 || imem_req !== 1'b0 || fetch_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL rm_reset: pc %h fv %b req %b fpc %h want 0 0 0 0", pc, fetch_valid, imem_req, fetch_pc);
    end
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (fetch_valid !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL rm_late_ack: fv %b addr %h req %b want 0 0 1", fetch_valid, imem_addr, imem_req);
    end
    exp_q.push_back(32'h0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_squash();
    test_priority();
    test_pending();
    test_stall();
    test_jr_in_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d expected transfers never seen, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side program-counter sequencer for the single-issue MIPS core.
- Consumes the word-aligned branch offset from the offset shift stage (sign-extended immediate << 2). Forms the branch, jump and jump-register targets.
- Owns the PC register and drives the instruction-memory request/acknowledge handshake.
- Presents each fetched PC to decode with a valid flag, honouring pipeline stall and redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Must be word aligned.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept; hold the current fetch.
- branch_taken  input  1  single-cycle redirect pulse: conditional branch resolved taken.
- branch_offset_sl2  input  32  shifted branch offset from the shift stage.
- jump  input  1  single-cycle redirect pulse: J/JAL.
- jump_index  input  26  instr_index field of J/JAL.
- jr  input  1  single-cycle redirect pulse: JR/JALR.
- jr_target  input  32  register-file value for JR/JALR.
- redirect_pc4  input  32  PC+4 of the redirecting instruction, supplied by decode.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address; equals pc.
- imem_ack  input  1  fetch complete, 1-cycle pulse, any latency >= 0 cycles after req.
- pc  output  32  current fetch PC.
- fetch_valid  output  1  the instruction at fetch_pc is available to decode.
- fetch_pc  output  32  PC of the instruction flagged by fetch_valid.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, fetch_pc=0, fetch_valid=0, imem_req=0.
  - pending redirect cleared; state=BOOT. Reset mid-handshake abandons the request; a late imem_ack is ignored while in BOOT.
- Target arithmetic (all modulo 2^32, no overflow flag):
  - branch target = redirect_pc4 + branch_offset_sl2.
  - jump target = {redirect_pc4[31:28], jump_index, 2'b00}.
  - jr target = jr_target, used unmodified.
  - Redirect priority when several pulses coincide: jr > jump > branch_taken.
- States:
  - BOOT: imem_req=0, redirects ignored. Next cycle -> REQ.
  - REQ: imem_req=1; imem_addr=pc held stable until imem_ack.
    - On ack with no redirect this cycle and none pending: fetch_valid<=1, fetch_pc<=pc. If stall=1 -> STALL with pc held. Otherwise pc<=pc+4 and stay in REQ, issuing the next request back-to-back.
    - Redirect without ack: latch target into pending; pc and imem_addr unchanged.
    - Redirect or pending redirect at ack: squash that fetch (fetch_valid<=0). pc<=target; a new redirect in the same cycle beats the pending one. Clear pending; stay in REQ.
    - No ack: fetch_valid<=0.
  - STALL: imem_req=0; fetch_valid=1 and fetch_pc held.
    - stall=0: fetch_valid<=0, pc<=pc+4 -> REQ. Decode consumes in the cycle stall is low.
    - Redirect in STALL (stall high or low): fetch_valid<=0, pc<=target -> REQ. Redirect overrides stall.
- A transfer to decode occurs in any cycle with fetch_valid=1 and stall=0.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no exception.

Test Plan:
- Reset then ack every cycle with RESET_PC=0: BOOT 1 cycle; fetch_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles; imem_req low only in BOOT.
- Branch with redirect_pc4=0x100, branch_offset_sl2=0xFFFF_FFF0, pulsed mid-wait (ack 2 cycles later): the in-flight fetch is squashed (no fetch_valid); next imem_addr=0xF0.
- jump and branch_taken pulsed together, redirect_pc4=0x4000_0010, jump_index=0x0000040: pc becomes 0x4000_0100; the branch is ignored.
- stall held 3 cycles after ack at pc=0x20: imem_req=0, fetch_valid=1 and fetch_pc=0x20 held; stall drops -> next imem_addr=0x24.
- jr to 0x8000_0000 during STALL: fetch_valid drops next cycle and imem_addr=0x8000_0000 even though stall is still high.
- rst asserted while imem_req=1 awaiting ack at pc=0x50, ack arrives the cycle after: outputs at reset values; the ack causes no fetch_valid; fetch resumes at RESET_PC.
